// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache/host line-transfer arbiter.
//   arb_state_e     - arbiter FSM state encoding
//   DEF_LINE_WORDS  - default words per cache line
//   OWN_I / OWN_D   - encoding of the requester that owns the current line
//   off_bits()      - number of byte-offset bits covered by one line
package cache_pkg;

    localparam int DEF_LINE_WORDS = 16;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WAIT_DONE,
        ST_DONE
    } arb_state_e;

    // Words are 32-bit, so a line spans log2(words) + 2 address bits.
    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/cache_arb_fsm.sv
// cache_arb_fsm: state register, next-state logic and word counter of the
// line-transfer arbiter.
//   req_any     - any requester pending (only looked at in IDLE)
//   cmd_wr      - latched direction of the current line (1 = writeback)
//   ready       - host accepts the command (CMD) or a write word (WR_DATA)
//   mem_rd_vld  - host read word valid
//   tx_done     - host finished the line transaction
//   state_q     - current state
//   cnt_q       - current word index within the line
//   err_evt     - protocol violation seen this cycle
module cache_arb_fsm import cache_pkg::*; #(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_any,
    input  logic             cmd_wr,
    input  logic             ready,
    input  logic             mem_rd_vld,
    input  logic             tx_done,
    output arb_state_e       state_q,
    output logic [IDX_W-1:0] cnt_q,
    output logic             err_evt
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_WORDS - 1);

    arb_state_e       state_d;
    logic [IDX_W-1:0] cnt_d;
    logic             word_ok;
    logic             last_word;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_evt   = 1'b0;
        word_ok   = 1'b0;
        last_word = (cnt_q == LAST);

        case (state_q)
            ST_IDLE: begin
                if (req_any) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (ready) begin
                    state_d = cmd_wr ? ST_WR_DATA : ST_RD_DATA;
                    cnt_d   = '0;
                end
            end
            ST_RD_DATA, ST_WR_DATA: begin
                word_ok = (state_q == ST_RD_DATA) ? mem_rd_vld : ready;
                // Counter saturates at the last index; only CMD exit rewinds it.
                if (word_ok && !last_word) cnt_d = cnt_q + 1'b1;
                if (tx_done) begin
                    // Host closing the line before its last word is a short line.
                    state_d = ST_DONE;
                    if (!(word_ok && last_word)) err_evt = 1'b1;
                end else if (word_ok && last_word) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stray host strobes are flagged but otherwise ignored.
        if (mem_rd_vld && (state_q != ST_RD_DATA)) err_evt = 1'b1;
        if (tx_done && !(state_q inside {ST_RD_DATA, ST_WR_DATA, ST_WAIT_DONE}))
            err_evt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_mem_arb.sv
// cache_mem_arb: moves one cache line at a time between the cache control
// and the host memory controller. D-side requests take priority over I-side.
//   i_req/i_addr                 - I-cache fill request
//   d_req/d_wr/d_addr            - D-cache fill (d_wr=0) or writeback (d_wr=1)
//   d_wb_data/d_wb_idx           - writeback word read from the cache by index
//   fill_we/dst/idx/data         - registered fill word write into a cache
//   i_done/d_done                - one-cycle completion per requester
//   xfer_err                     - sticky host protocol error
//   mem_cmd_vld/wr/addr, ready   - host line command handshake
//   mem_wr_vld/data              - write words to host (accepted on ready)
//   mem_rd_vld/data, tx_done     - read words and end-of-line from host
module cache_mem_arb import cache_pkg::*; #(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ADDR_W     = 32,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wb_data,
    output logic [IDX_W-1:0]  d_wb_idx,
    output logic              fill_we,
    output logic              fill_dst,
    output logic [IDX_W-1:0]  fill_idx,
    output logic [31:0]       fill_data,
    output logic              i_done,
    output logic              d_done,
    output logic              xfer_err,
    output logic              mem_cmd_vld,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    input  logic              ready,
    output logic              mem_wr_vld,
    output logic [31:0]       mem_wr_data,
    input  logic              mem_rd_vld,
    input  logic [31:0]       mem_rd_data,
    input  logic              tx_done
);

    localparam int OFF_W = off_bits(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    arb_state_e       state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             err_evt;
    logic             req_any;

    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              wr_d, wr_q;
    logic              own_d, own_q;
    logic              xfer_err_d, xfer_err_q;
    logic              fill_we_d, fill_we_q;
    logic              fill_dst_d, fill_dst_q;
    logic [IDX_W-1:0]  fill_idx_d, fill_idx_q;
    logic [31:0]       fill_data_d, fill_data_q;

    assign req_any = i_req | d_req;

    cache_arb_fsm #(.LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W)) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_any    (req_any),
        .cmd_wr     (wr_q),
        .ready      (ready),
        .mem_rd_vld (mem_rd_vld),
        .tx_done    (tx_done),
        .state_q    (state_q),
        .cnt_q      (cnt_q),
        .err_evt    (err_evt)
    );

    always_comb begin
        addr_d      = addr_q;
        wr_d        = wr_q;
        own_d       = own_q;
        xfer_err_d  = xfer_err_q | err_evt;
        fill_we_d   = (state_q == ST_RD_DATA) && mem_rd_vld;
        fill_dst_d  = fill_dst_q;
        fill_idx_d  = fill_idx_q;
        fill_data_d = fill_data_q;

        // Request latch: D wins, a simultaneous I request simply stays pending.
        if ((state_q == ST_IDLE) && req_any) begin
            own_d  = d_req ? OWN_D : OWN_I;
            wr_d   = d_req & d_wr;
            addr_d = (d_req ? d_addr : i_addr) & LINE_MASK;
        end

        if (fill_we_d) begin
            fill_dst_d  = own_q;
            fill_idx_d  = cnt_q;
            fill_data_d = mem_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wr_q        <= 1'b0;
            own_q       <= OWN_I;
            xfer_err_q  <= 1'b0;
            fill_we_q   <= 1'b0;
            fill_dst_q  <= 1'b0;
            fill_idx_q  <= '0;
            fill_data_q <= '0;
        end else begin
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            own_q       <= own_d;
            xfer_err_q  <= xfer_err_d;
            fill_we_q   <= fill_we_d;
            fill_dst_q  <= fill_dst_d;
            fill_idx_q  <= fill_idx_d;
            fill_data_q <= fill_data_d;
        end
    end

    assign mem_cmd_vld  = (state_q == ST_CMD);
    assign mem_cmd_wr   = mem_cmd_vld & wr_q;
    assign mem_cmd_addr = addr_q;
    assign mem_wr_vld   = (state_q == ST_WR_DATA);
    // Writeback data comes straight from the cache's async read port.
    assign mem_wr_data  = mem_wr_vld ? d_wb_data : '0;
    assign d_wb_idx     = cnt_q;
    assign i_done       = (state_q == ST_DONE) && (own_q == OWN_I);
    assign d_done       = (state_q == ST_DONE) && (own_q == OWN_D);
    assign xfer_err     = xfer_err_q;
    assign fill_we      = fill_we_q;
    assign fill_dst     = fill_dst_q;
    assign fill_idx     = fill_idx_q;
    assign fill_data    = fill_data_q;

endmodule

// File: tb/tb_cache_mem_arb.sv
module tb_cache_mem_arb;

    localparam int LW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_wr;
    logic [AW-1:0] i_addr, d_addr;
    logic [31:0]   d_wb_data;
    logic [3:0]    d_wb_idx;
    logic          fill_we, fill_dst;
    logic [3:0]    fill_idx;
    logic [31:0]   fill_data;
    logic          i_done, d_done, xfer_err;
    logic          mem_cmd_vld, mem_cmd_wr;
    logic [AW-1:0] mem_cmd_addr;
    logic          ready, mem_wr_vld, mem_rd_vld, tx_done;
    logic [31:0]   mem_wr_data, mem_rd_data;

    int checks = 0;
    int errors = 0;
    int wr_acc = 0;

    typedef struct { logic dst; logic [3:0] idx; logic [31:0] data; } fill_t;
    typedef struct { logic [3:0] idx; logic [31:0] data; } wr_t;
    fill_t fill_exp[$];
    wr_t   wr_exp[$];
    logic  done_exp[$];   // expected owner: 0 = I, 1 = D

    logic [31:0] wb_line [LW];
    assign d_wb_data = wb_line[d_wb_idx];

    cache_mem_arb #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr),
        .d_wb_data(d_wb_data), .d_wb_idx(d_wb_idx),
        .fill_we(fill_we), .fill_dst(fill_dst), .fill_idx(fill_idx), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .xfer_err(xfer_err),
        .mem_cmd_vld(mem_cmd_vld), .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr),
        .ready(ready), .mem_wr_vld(mem_wr_vld), .mem_wr_data(mem_wr_data),
        .mem_rd_vld(mem_rd_vld), .mem_rd_data(mem_rd_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: pops expectations as the DUT produces output.
    fill_t fe;
    wr_t   we;
    logic  de;
    always @(negedge clk) begin
        if (rst_n) begin
            if (fill_we) begin
                checks++;
                if (fill_exp.size() == 0) begin
                    errors++;
                    $display("FAIL fill_unexpected dst=%0d idx=%0d data=%h required no fill", fill_dst, fill_idx, fill_data);
                end else begin
                    fe = fill_exp.pop_front();
                    if ({fill_dst, fill_idx, fill_data} !== {fe.dst, fe.idx, fe.data}) begin
                        errors++;
                        $display("FAIL fill_word got dst=%0d idx=%0d data=%h required dst=%0d idx=%0d data=%h",
                                 fill_dst, fill_idx, fill_data, fe.dst, fe.idx, fe.data);
                    end
                end
            end
            if (mem_wr_vld && ready) begin
                checks++;
                wr_acc++;
                if (wr_exp.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected idx=%0d data=%h required no write", d_wb_idx, mem_wr_data);
                end else begin
                    we = wr_exp.pop_front();
                    if ({d_wb_idx, mem_wr_data} !== {we.idx, we.data}) begin
                        errors++;
                        $display("FAIL wr_word got idx=%0d data=%h required idx=%0d data=%h",
                                 d_wb_idx, mem_wr_data, we.idx, we.data);
                    end
                end
            end
            if (i_done || d_done) begin
                checks++;
                if (done_exp.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected i=%0d d=%0d required none", i_done, d_done);
                end else begin
                    de = done_exp.pop_front();
                    if ({i_done, d_done} !== {~de, de}) begin
                        errors++;
                        $display("FAIL done_owner got i=%0d d=%0d required i=%0d d=%0d", i_done, d_done, ~de, de);
                    end
                end
            end
        end
    end

    // Stimulus helpers (no checking inside).
    task automatic wait_cmd(output int cyc, output bit seen);
        seen = 0;
        cyc  = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_cmd_vld) begin
                seen = 1;
                return;
            end
        end
    endtask

    task automatic feed_read(input logic dst, input logic [31:0] base, input int n, input bit tx_last);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            mem_rd_vld  = 1'b1;
            mem_rd_data = base + 32'(k);
            tx_done     = tx_last && (k == n - 1);
            fill_exp.push_back('{dst, 4'(k), base + 32'(k)});
        end
        @(posedge clk); #1;
        mem_rd_vld = 1'b0;
        tx_done    = 1'b0;
    endtask

    task automatic wait_done(output bit got_i, output bit got_d);
        got_i = 0;
        got_d = 0;
        for (int c = 0; c < 50; c++) begin
            if (i_done || d_done) begin
                got_i = i_done;
                got_d = d_done;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_req = 0; d_req = 0; d_wr = 0; i_addr = '0; d_addr = '0;
        ready = 0; mem_rd_vld = 0; mem_rd_data = '0; tx_done = 0;
        for (int k = 0; k < LW; k++) wb_line[k] = '0;
        #12;
        checks++;
        if ({mem_cmd_vld, mem_cmd_wr, mem_wr_vld, fill_we, i_done, d_done, xfer_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 0000000",
                     {mem_cmd_vld, mem_cmd_wr, mem_wr_vld, fill_we, i_done, d_done, xfer_err});
        end
        checks++;
        if ({mem_cmd_addr, d_wb_idx, fill_idx, fill_data, mem_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h wb_idx=%0d fill_idx=%0d fill_data=%h required all 0",
                     mem_cmd_addr, d_wb_idx, fill_idx, fill_data);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_cmd_vld !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_cmd got %b required 0", mem_cmd_vld);
        end
    endtask

    task automatic test_i_fill;
        int cyc; bit seen, gi, gd;
        i_addr = 32'h0000_1234; i_req = 1'b1; ready = 1'b1;
        done_exp.push_back(1'b0);
        wait_cmd(cyc, seen);
        checks++;
        if (!seen || cyc != 1 || mem_cmd_addr !== 32'h0000_1200 || mem_cmd_wr !== 1'b0) begin
            errors++;
            $display("FAIL ifill_cmd seen=%0d cyc=%0d addr=%h wr=%b required 1 1 00001200 0",
                     seen, cyc, mem_cmd_addr, mem_cmd_wr);
        end
        feed_read(1'b0, 32'hA0, LW, 1'b1);
        wait_done(gi, gd);
        i_req = 1'b0;
        checks++;
        if ({gi, gd} !== 2'b10) begin
            errors++;
            $display("FAIL ifill_done got i=%0d d=%0d required i=1 d=0", gi, gd);
        end
        @(posedge clk); #1;
        checks++;
        if (fill_exp.size() != 0 || xfer_err !== 1'b0) begin
            errors++;
            $display("FAIL ifill_drain left=%0d err=%b required 0 0", fill_exp.size(), xfer_err);
        end
    endtask

    task automatic test_priority;
        int cyc; bit seen, gi, gd;
        d_addr = 32'h0000_5678; d_wr = 1'b0; i_addr = 32'h0000_9010;
        d_req = 1'b1; i_req = 1'b1;
        done_exp.push_back(1'b1);
        done_exp.push_back(1'b0);
        wait_cmd(cyc, seen);
        checks++;
        if (!seen || mem_cmd_addr !== 32'h0000_5640 || mem_cmd_wr !== 1'b0) begin
            errors++;
            $display("FAIL prio_dcmd seen=%0d addr=%h wr=%b required 1 00005640 0", seen, mem_cmd_addr, mem_cmd_wr);
        end
        feed_read(1'b1, 32'hB0, LW, 1'b1);
        wait_done(gi, gd);
        d_req = 1'b0;
        checks++;
        if ({gi, gd} !== 2'b01) begin
            errors++;
            $display("FAIL prio_ddone got i=%0d d=%0d required i=0 d=1", gi, gd);
        end
        wait_cmd(cyc, seen);
        checks++;
        if (!seen || cyc != 2 || mem_cmd_addr !== 32'h0000_9000) begin
            errors++;
            $display("FAIL prio_icmd seen=%0d cyc=%0d addr=%h required 1 2 00009000", seen, cyc, mem_cmd_addr);
        end
        feed_read(1'b0, 32'hC0, LW, 1'b1);
        wait_done(gi, gd);
        i_req = 1'b0;
        checks++;
        if ({gi, gd} !== 2'b10) begin
            errors++;
            $display("FAIL prio_idone got i=%0d d=%0d required i=1 d=0", gi, gd);
        end
    endtask

    task automatic test_write;
        int cyc; bit seen, gi, gd;
        for (int k = 0; k < LW; k++) begin
            wb_line[k] = 32'hD000_0000 + 32'(k) * 32'h111;
            wr_exp.push_back('{4'(k), 32'hD000_0000 + 32'(k) * 32'h111});
        end
        wr_acc = 0;
        d_addr = 32'h0001_00C4; d_wr = 1'b1; d_req = 1'b1; ready = 1'b1;
        done_exp.push_back(1'b1);
        wait_cmd(cyc, seen);
        checks++;
        if (!seen || mem_cmd_addr !== 32'h0001_00C0 || mem_cmd_wr !== 1'b1) begin
            errors++;
            $display("FAIL wb_cmd seen=%0d addr=%h wr=%b required 1 000100C0 1", seen, mem_cmd_addr, mem_cmd_wr);
        end
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (wr_acc >= LW) break;
            if (mem_wr_vld) begin
                checks++;
                if (d_wb_idx !== 4'(wr_acc)) begin
                    errors++;
                    $display("FAIL wb_idx_hold got %0d required %0d", d_wb_idx, wr_acc);
                end
            end
            ready = ~ready;
        end
        ready = 1'b0;
        checks++;
        if (wr_acc != LW || mem_wr_vld !== 1'b0 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL wb_count acc=%0d wr_vld=%b d_done=%b required 16 0 0", wr_acc, mem_wr_vld, d_done);
        end
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        wait_done(gi, gd);
        d_req = 1'b0; d_wr = 1'b0; ready = 1'b1;
        checks++;
        if ({gi, gd} !== 2'b01 || wr_exp.size() != 0 || xfer_err !== 1'b0) begin
            errors++;
            $display("FAIL wb_done i=%0d d=%0d left=%0d err=%b required 0 1 0 0", gi, gd, wr_exp.size(), xfer_err);
        end
    endtask

    task automatic test_early_tx;
        int cyc; bit seen, gi, gd;
        i_addr = 32'h0000_2000; i_req = 1'b1;
        done_exp.push_back(1'b0);
        wait_cmd(cyc, seen);
        feed_read(1'b0, 32'hE0, 8, 1'b1);
        wait_done(gi, gd);
        i_req = 1'b0;
        checks++;
        if ({gi, gd} !== 2'b10 || xfer_err !== 1'b1) begin
            errors++;
            $display("FAIL early_tx i=%0d d=%0d err=%b required 1 0 1", gi, gd, xfer_err);
        end
        d_addr = 32'h0000_3000; d_wr = 1'b0; d_req = 1'b1;
        done_exp.push_back(1'b1);
        wait_cmd(cyc, seen);
        checks++;
        if (!seen || mem_cmd_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL early_next_cmd seen=%0d addr=%h required 1 00003000", seen, mem_cmd_addr);
        end
        feed_read(1'b1, 32'hF0, LW, 1'b1);
        wait_done(gi, gd);
        d_req = 1'b0;
        checks++;
        if ({gi, gd} !== 2'b01) begin
            errors++;
            $display("FAIL early_next_done got i=%0d d=%0d required 0 1", gi, gd);
        end
    endtask

    task automatic test_reset_mid;
        int cyc; bit seen, gi, gd;
        i_addr = 32'h0000_4000; i_req = 1'b1;
        wait_cmd(cyc, seen);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            mem_rd_vld  = 1'b1;
            mem_rd_data = 32'h100 + 32'(k);
            if (k < 4) fill_exp.push_back('{1'b0, 4'(k), 32'h100 + 32'(k)});
        end
        #6;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_cmd_vld, mem_wr_vld, fill_we, i_done, d_done, xfer_err} !== 6'b0 ||
            {mem_cmd_addr, d_wb_idx, fill_idx, fill_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid ctrl=%b addr=%h fill_idx=%0d fill_data=%h required all 0",
                     {mem_cmd_vld, mem_wr_vld, fill_we, i_done, d_done, xfer_err}, mem_cmd_addr, fill_idx, fill_data);
        end
        mem_rd_vld = 1'b0; i_req = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        d_addr = 32'h0000_6000; d_wr = 1'b0; d_req = 1'b1;
        done_exp.push_back(1'b1);
        wait_cmd(cyc, seen);
        checks++;
        if (!seen || mem_cmd_addr !== 32'h0000_6000) begin
            errors++;
            $display("FAIL rst_next_cmd seen=%0d addr=%h required 1 00006000", seen, mem_cmd_addr);
        end
        feed_read(1'b1, 32'h200, LW, 1'b1);
        wait_done(gi, gd);
        d_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (gd !== 1'b1 || xfer_err !== 1'b0 || fill_exp.size() != 0) begin
            errors++;
            $display("FAIL rst_next_done d=%0d err=%b left=%0d required 1 0 0", gd, xfer_err, fill_exp.size());
        end
    endtask

    task automatic test_stray_rd;
        mem_rd_vld = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rd_vld = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (xfer_err !== 1'b1 || fill_we !== 1'b0 || mem_cmd_vld !== 1'b0) begin
            errors++;
            $display("FAIL stray_rd err=%b fill_we=%b cmd=%b required 1 0 0", xfer_err, fill_we, mem_cmd_vld);
        end
    endtask

    initial begin
        test_reset;
        test_i_fill;
        test_priority;
        test_write;
        test_early_tx;
        test_reset_mid;
        test_stray_rd;
        repeat (3) @(posedge clk);
        checks++;
        if (fill_exp.size() != 0 || wr_exp.size() != 0 || done_exp.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover fill=%0d wr=%0d done=%0d required 0 0 0",
                     fill_exp.size(), wr_exp.size(), done_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arb.md
# cache_mem_arb

Line-transfer arbiter between the cache control FSM and the host memory controller. Accepts one line request at a time (I-cache fill, D-cache fill, or D-cache writeback), issues a single line-aligned command to the host, streams line words between host and cache, and pulses a per-requester done. D-side requests win over I-side, matching the cache control service order.

## Interface
- LINE_WORDS, 16: words per cache line; power of two, ≥2.
- ADDR_W, 32: address width.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  I-cache fill request, level; held until i_done.
- i_addr  in  ADDR_W  I-cache miss address; low offset bits ignored.
- d_req  in  1  D-cache request, level; held until d_done.
- d_wr  in  1  1 = writeback, 0 = fill; sampled with d_req.
- d_addr  in  ADDR_W  D-cache line address.
- d_wb_data  in  32  writeback word at d_wb_idx, valid same cycle (async cache read).
- d_wb_idx  out  log2(LINE_WORDS)  current writeback word index.
- fill_we  out  1  fill word write strobe.
- fill_dst  out  1  0 = I-cache, 1 = D-cache.
- fill_idx  out  log2(LINE_WORDS)  fill word index.
- fill_data  out  32  fill word.
- i_done / d_done  out  1  one-cycle completion pulse.
- xfer_err  out  1  sticky protocol error; cleared only by reset.
- mem_cmd_vld  out  1  host command valid.
- mem_cmd_wr  out  1  1 = line write, 0 = line read.
- mem_cmd_addr  out  ADDR_W  line-aligned address (low log2(LINE_WORDS)+2 bits zero).
- ready  in  1  host ready: accepts command, or accepts write word.
- mem_wr_vld / mem_wr_data  out  1 / 32  write word valid / data.
- mem_rd_vld / mem_rd_data  in  1 / 32  read word valid / data.
- tx_done  in  1  host finished current line transaction.

## Operation
- States: IDLE, CMD, RD_DATA, WR_DATA, WAIT_DONE, DONE.
- IDLE: d_req → latch d_addr, d_wr, owner=D; else i_req → latch i_addr, owner=I; go CMD. Simultaneous requests: D served, I stays pending.
- CMD: mem_cmd_vld=1 with latched addr/dir; on ready → RD_DATA (read) or WR_DATA (write), word counter=0.
- RD_DATA: each mem_rd_vld captures mem_rd_data; counter increments; after word LINE_WORDS-1 → WAIT_DONE (or DONE if tx_done same cycle).
- WR_DATA: mem_wr_vld=1, mem_wr_data=d_wb_data, d_wb_idx=counter; word accepted when ready=1; after last accepted word → WAIT_DONE (or DONE if tx_done same cycle).
- WAIT_DONE: hold until tx_done → DONE.
- DONE: pulse i_done or d_done per owner; → IDLE.
- Errors (set xfer_err, continue): mem_rd_vld outside RD_DATA ignored; tx_done before all words → DONE immediately, remaining words not written; tx_done outside data/WAIT_DONE ignored.
- Requester dropping req mid-transfer does not abort; done still pulses.
- Counter wraps only via reset to 0 at CMD exit; never exceeds LINE_WORDS-1.

## Timing
- Reset: state IDLE, all outputs 0, counter 0, xfer_err 0.
- Command visible the cycle after IDLE sees request; held stable until ready.
- fill_we/fill_idx/fill_data registered: one cycle after the mem_rd_vld sample.
- Done pulse one cycle after tx_done sampled; earliest new command two cycles after done.
- Read line min latency from request: 1 (CMD) + LINE_WORDS + 1 (DONE) + handshake waits.
- Reset mid-transfer: immediate return to IDLE; partial fill is discarded by cache control (its valid bit never set).

## Structure
- Shared package cache_pkg: state enum, LINE_WORDS, offset-bit constant, owner encoding (OWN_I/OWN_D).
- One natural sub-module: cache_arb_fsm (state register, next-state, counter); datapath registers in top.

## Test plan
- i_req, addr 0x0000_1234, ready=1, 16 read words 0xA0..0xAF → mem_cmd_addr 0x0000_1200, fill_dst=0, fill_idx 0..15 with matching data, one i_done.
- d_req+i_req same cycle, d_wr=0 → D line fully served and d_done, then I command issued; no interleaved fill_dst.
- d_wr=1, ready toggling 1/0 every cycle → 16 distinct words accepted in index order, d_wb_idx advances only on ready, d_done after tx_done.
- tx_done after 8 read words → xfer_err=1, i_done pulses, next request served normally.
- rst_n low during word 5 of a read → all outputs 0 asynchronously, IDLE; new request after release completes cleanly.
- Stray mem_rd_vld in IDLE → xfer_err=1, no fill_we.
